tc_sram_banked: RTL and testbench

- Multi-port, word-interleaved, banked functional SRAM model with a request/grant handshake. Each bank is single-ported.
- Per-bank round-robin arbitration resolves port conflicts; read responses carry a `rvalid_o` strobe after a fixed latency.
- Drop-in functional model for shared L1/TCDM-style memories, where `tc_sram`'s all-ports-always-succeed model is unrealistic.

---
 rtl/tc_sram_banked_pkg.sv | 19 +
 rtl/tc_sram_rr_arb.sv | 37 +++
 rtl/tc_sram_banked.sv | 125 ++++++++++++
 tb/tb_tc_sram_banked.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sram_banked_pkg.sv
// Shared helpers for the banked SRAM model: address decode into bank/row and
// the recognised SimInit values.
package tc_sram_banked_pkg;

  localparam string SIM_INIT_ZEROS  = "zeros";
  localparam string SIM_INIT_ONES   = "ones";
  localparam string SIM_INIT_RANDOM = "random";
  localparam string SIM_INIT_NONE   = "none";

  // Banks are a power of two, so these reduce to a bit slice and a shift.
  function automatic int unsigned bank_sel(input logic [31:0] addr, input int unsigned num_banks);
    return addr % num_banks;
  endfunction

  function automatic int unsigned row_sel(input logic [31:0] addr, input int unsigned num_banks);
    return addr / num_banks;
  endfunction

endpackage

// File: rtl/tc_sram_rr_arb.sv
// Round-robin arbiter for one bank: one-hot grant to the first requester at or
// after the pointer; the pointer moves past the winner.
module tc_sram_rr_arb #(
  parameter int unsigned NumReq = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d, idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = PtrW'((int'(ptr_q) + k) % NumReq);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PtrW'((int'(idx) + 1) % NumReq);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tc_sram_banked.sv
// Word-interleaved multi-port SRAM model: single-ported banks, per-bank
// round-robin arbitration, fixed-latency read return per port.
module tc_sram_banked
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter string       SimInit   = "none",
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam int unsigned Rows  = NumWords / NumBanks;
  localparam int unsigned RowW  = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned BankW = (NumBanks > 1) ? $clog2(NumBanks) : 1;

  logic [DataWidth-1:0] mem_q [NumBanks][Rows];

  logic [NumPorts-1:0][BankW-1:0]     bank;
  logic [NumPorts-1:0][RowW-1:0]      row;
  logic [NumPorts-1:0]                in_range, rd_gnt;
  logic [NumPorts-1:0][DataWidth-1:0] rd_data;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_req, bank_gnt;

  logic [Latency-1:0][NumPorts-1:0]                vld_q;
  logic [Latency-1:0][NumPorts-1:0][DataWidth-1:0] dat_q;

  // Fixed hash rather than a true RNG so "random" content stays synthesizable.
  function automatic logic [DataWidth-1:0] init_word(input int unsigned idx);
    if (SimInit == SIM_INIT_ZEROS) return '0;
    if (SimInit == SIM_INIT_ONES)  return '1;
    return DataWidth'((idx * 32'h9E37_79B9) ^ 32'h5BD1_E995);
  endfunction

  // Out-of-range addresses still decode to a bank so they arbitrate normally.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      in_range[p] = 32'(addr_i[p]) < NumWords;
      bank[p]     = BankW'(bank_sel(32'(addr_i[p]), NumBanks));
      row[p]      = in_range[p] ? RowW'(row_sel(32'(addr_i[p]), NumBanks)) : '0;
      rd_data[p]  = in_range[p] ? mem_q[bank[p]][row[p]] : '0;
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++)
      for (int p = 0; p < NumPorts; p++)
        bank_req[b][p] = req_i[p] && (bank[p] == BankW'(b));
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    tc_sram_rr_arb #(.NumReq(NumPorts)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (bank_req[b]),
      .gnt_o  (bank_gnt[b])
    );
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NumBanks; b++) gnt_o = gnt_o | bank_gnt[b];
  end

  assign rd_gnt = gnt_o & ~we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (SimInit != SIM_INIT_NONE)
        for (int b = 0; b < NumBanks; b++)
          for (int r = 0; r < Rows; r++)
            mem_q[b][r] <= init_word(r * NumBanks + b);
    end else begin
      for (int p = 0; p < NumPorts; p++)
        if (gnt_o[p] && we_i[p] && in_range[p])
          for (int j = 0; j < DataWidth; j++)
            if (be_i[p][j / ByteWidth]) mem_q[bank[p]][row[p]][j] <= wdata_i[p][j];
    end
  end

  // Data stages only load alongside a valid, so the last stage holds the
  // most recently returned word between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= rd_gnt;
      for (int p = 0; p < NumPorts; p++)
        if (rd_gnt[p]) dat_q[0][p] <= rd_data[p];
      for (int s = 1; s < Latency; s++) begin
        vld_q[s] <= vld_q[s-1];
        for (int p = 0; p < NumPorts; p++)
          if (vld_q[s-1][p]) dat_q[s][p] <= dat_q[s-1][p];
      end
    end
  end

  assign rvalid_o = vld_q[Latency-1];
  assign rdata_o  = dat_q[Latency-1];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++)
      if (rst_ni && rd_gnt[p] && !in_range[p])
        $warning("tc_sram_banked: port %0d read of out-of-range address %0d", p, addr_i[p]);
  end
`endif

endmodule

// File: tb/tb_tc_sram_banked.sv
// Bench for tc_sram_banked: directed scenarios plus random traffic, checked
// against a word-array / grant-cycle reference model.
module tb_tc_sram_banked;

  localparam int NW = 12, NB = 2, NP = 2, DW = 32, LAT = 2, AW = 4, BEW = 4, BW = 8;
  localparam int MAXC = 512;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [NP-1:0]          req_i, we_i, gnt_o, rvalid_o;
  logic [NP-1:0][AW-1:0]  addr_i;
  logic [NP-1:0][DW-1:0]  wdata_i, rdata_o;
  logic [NP-1:0][BEW-1:0] be_i;

  tc_sram_banked #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(BW), .NumPorts(NP),
    .NumBanks(NB), .Latency(LAT), .SimInit("zeros")
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] req, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BEW-1:0] b0, b1;
  } stim_t;

  int total = 0, bad = 0, cyc = 0;
  int ptr [NB];
  logic [DW-1:0] mm [NW];
  bit            rv_vld [NP][MAXC];
  logic [DW-1:0] rv_dat [NP][MAXC];
  logic [NP-1:0] exp_gnt, exp_rv, m_req, m_we;
  logic [NP-1:0][DW-1:0]  exp_rd, m_d;
  logic [NP-1:0][AW-1:0]  m_a;
  logic [NP-1:0][BEW-1:0] m_b;

  function automatic stim_t mk(input logic [1:0] req, we, input logic [AW-1:0] a0, a1,
                               input logic [DW-1:0] d0, d1, input logic [BEW-1:0] b0, b1);
    stim_t s;
    s.req = req; s.we = we; s.a0 = a0; s.a1 = a1; s.d0 = d0; s.d1 = d1; s.b0 = b0; s.b1 = b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int w = 0; w < NW; w++) mm[w] = '0;
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < MAXC; c++) begin rv_vld[p][c] = 1'b0; rv_dat[p][c] = '0; end
    exp_rd = '0;
    exp_rv = '0;
    cyc = 0;
  endtask

  // Called once per cycle at the falling edge: apply inputs, derive expectations.
  task automatic drive(input stim_t s);
    bit taken;
    m_req = s.req; m_we = s.we;
    m_a[0] = s.a0; m_a[1] = s.a1; m_d[0] = s.d0; m_d[1] = s.d1; m_b[0] = s.b0; m_b[1] = s.b1;
    req_i = m_req; we_i = m_we; addr_i = m_a; wdata_i = m_d; be_i = m_b;
    exp_gnt = '0;
    for (int b = 0; b < NB; b++) begin
      taken = 1'b0;
      for (int k = 0; k < NP; k++) begin
        int i;
        i = (ptr[b] + k) % NP;
        if (!taken && m_req[i] && (int'(m_a[i]) % NB == b)) begin exp_gnt[i] = 1'b1; taken = 1'b1; end
      end
    end
    for (int p = 0; p < NP; p++) begin
      exp_rv[p] = (cyc >= LAT) && rv_vld[p][cyc-LAT];
      if (exp_rv[p]) exp_rd[p] = rv_dat[p][cyc-LAT];
    end
    #1;
  endtask

  task automatic tick();
    for (int p = 0; p < NP; p++)
      if (exp_gnt[p]) begin
        ptr[int'(m_a[p]) % NB] = (p + 1) % NP;
        if (!m_we[p]) begin
          rv_vld[p][cyc] = 1'b1;
          rv_dat[p][cyc] = (int'(m_a[p]) < NW) ? mm[int'(m_a[p])] : '0;
        end
      end
    for (int p = 0; p < NP; p++)
      if (exp_gnt[p] && m_we[p] && int'(m_a[p]) < NW)
        for (int j = 0; j < DW; j++)
          if (m_b[p][j/BW]) mm[int'(m_a[p])][j] = m_d[p][j];
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    model_reset();
    @(negedge clk_i); #1;
    total++; if (rvalid_o !== '0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
    total++; if (rdata_o !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++; if (rvalid_o !== '0 || gnt_o !== '0) begin bad++; $display("FAIL post_reset_idle rvalid=%b gnt=%b exp=0/0", rvalid_o, gnt_o); end
    @(negedge clk_i);
  endtask

  task automatic test_write_read();
    stim_t st [4];
    bit rv0_seen = 1'b0;
    st[0] = mk(2'b01, 2'b01, 4'd4, 4'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
    st[1] = mk(2'b10, 2'b00, 4'd0, 4'd4, 32'h0, 32'h0, 4'h0, 4'h0);
    st[2] = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[3] = st[2];
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      if (rvalid_o[0]) rv0_seen = 1'b1;
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL wr_rd_gnt step%0d got=%b exp=%b", i, gnt_o, exp_gnt); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL wr_rd_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      tick();
    end
    total++; if (rdata_o[1] !== 32'hDEADBEEF || rv0_seen) begin bad++; $display("FAIL wr_rd_final rdata1=%h rv0_seen=%0d exp=deadbeef/0", rdata_o[1], rv0_seen); end
  endtask

  task automatic test_conflict();
    stim_t st [6];
    logic [1:0] lg [6];
    do_reset();
    st[0] = mk(2'b11, 2'b00, 4'd2, 4'd6, 32'h0, 32'h0, 4'h0, 4'h0);
    st[1] = mk(2'b10, 2'b00, 4'd0, 4'd6, 32'h0, 32'h0, 4'h0, 4'h0);
    st[2] = mk(2'b11, 2'b00, 4'd3, 4'd6, 32'h0, 32'h0, 4'h0, 4'h0);
    st[3] = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[4] = st[3]; st[5] = st[3];
    lg = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      total++; if (gnt_o !== lg[i] || gnt_o !== exp_gnt) begin bad++; $display("FAIL conflict_gnt step%0d got=%b exp=%b", i, gnt_o, lg[i]); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL conflict_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      tick();
    end
  endtask

  task automatic test_byte_enable();
    stim_t st [5];
    st[0] = mk(2'b01, 2'b01, 4'd5, 4'd0, 32'h11223344, 32'h0, 4'hF, 4'h0);
    st[1] = mk(2'b01, 2'b01, 4'd5, 4'd0, 32'hAABBCCDD, 32'h0, 4'b0101, 4'h0);
    st[2] = mk(2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[3] = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[4] = st[3];
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL be_gnt step%0d got=%b exp=%b", i, gnt_o, exp_gnt); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL be_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      tick();
    end
    total++; if (rdata_o[0] !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge got=%h exp=11bb33dd", rdata_o[0]); end
  endtask

  task automatic test_back_to_back();
    stim_t st [18];
    int k = 0, first = -1;
    for (int a = 0; a < 8; a++) st[a] = mk(2'b01, 2'b01, 4'(a), 4'd0, 32'(a*3), 32'h0, 4'hF, 4'h0);
    for (int a = 0; a < 8; a++) st[8+a] = mk(2'b01, 2'b00, 4'(a), 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[16] = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[17] = st[16];
    for (int i = 0; i < 18; i++) begin
      drive(st[i]);
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL b2b_gnt step%0d got=%b exp=%b", i, gnt_o, exp_gnt); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL b2b_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      if (rvalid_o[0]) begin
        if (first < 0) first = i;
        total++; if (rdata_o[0] !== 32'(k*3) || i != first + k) begin bad++; $display("FAIL b2b_seq beat%0d got=%h exp=%h", k, rdata_o[0], k*3); end
        k++;
      end
      tick();
    end
    total++; if (k != 8 || first != 10) begin bad++; $display("FAIL b2b_count beats=%0d first=%0d exp=8/10", k, first); end
  endtask

  task automatic test_out_of_range();
    stim_t st [6];
    st[0] = mk(2'b01, 2'b01, 4'd1, 4'd0, 32'h01010101, 32'h0, 4'hF, 4'h0);
    st[1] = mk(2'b01, 2'b01, 4'd13, 4'd0, 32'hFFFFFFFF, 32'h0, 4'hF, 4'h0);
    st[2] = mk(2'b01, 2'b00, 4'd13, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[3] = mk(2'b01, 2'b00, 4'd1, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[4] = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    st[5] = st[4];
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL oor_gnt step%0d got=%b exp=%b", i, gnt_o, exp_gnt); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL oor_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      if (i == 4) begin
        total++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 32'h0) begin bad++; $display("FAIL oor_read got=%b/%h exp=1/0", rvalid_o[0], rdata_o[0]); end
      end
      tick();
    end
    total++; if (rdata_o[0] !== 32'h01010101) begin bad++; $display("FAIL oor_alias got=%h exp=01010101", rdata_o[0]); end
  endtask

  task automatic test_reset_mid();
    stim_t idle;
    idle = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(mk(2'b01, 2'b00, 4'd4, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0));
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rstmid_gnt got=%b exp=01", gnt_o); end
    tick();
    rst_ni = 1'b0;
    req_i = '0; we_i = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rvalid_o !== '0 || rdata_o !== '0) begin bad++; $display("FAIL rstmid_hold cyc%0d got=%b/%h exp=0/0", i, rvalid_o, rdata_o); end
      @(negedge clk_i);
    end
    rst_ni = 1'b1;
    drive(mk(2'b11, 2'b00, 4'd0, 4'd2, 32'h0, 32'h0, 4'h0, 4'h0));
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rstmid_ptr got=%b exp=01", gnt_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(idle);
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL rstmid_resp step%0d got=%b/%h exp=%b/%h", i, rvalid_o, rdata_o, exp_rv, exp_rd); end
      tick();
    end
  endtask

  task automatic test_random();
    stim_t s, prev;
    logic [NP-1:0] held = '0;
    do_reset();
    prev = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    for (int n = 0; n < 320; n++) begin
      if (n < 300)
        s = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, NW-1)), 4'($urandom_range(0, NW-1)),
               $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        s = mk(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      // A refused request is re-presented unchanged.
      if (held[0]) begin s.req[0] = 1'b1; s.we[0] = prev.we[0]; s.a0 = prev.a0; s.d0 = prev.d0; s.b0 = prev.b0; end
      if (held[1]) begin s.req[1] = 1'b1; s.we[1] = prev.we[1]; s.a1 = prev.a1; s.d1 = prev.d1; s.b1 = prev.b1; end
      drive(s);
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL rand_gnt n%0d got=%b exp=%b", n, gnt_o, exp_gnt); end
      total++; if (rvalid_o !== exp_rv || rdata_o !== exp_rd) begin bad++; $display("FAIL rand_resp n%0d got=%b/%h exp=%b/%h", n, rvalid_o, rdata_o, exp_rv, exp_rd); end
      held = s.req & ~exp_gnt;
      prev = s;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
